// File: rtl/conv3_writeback_if.sv
// Stream-in / memory-out bundle for the conv3 writeback stage.
// The slave side is the writeback block; the master side feeds results and observes the output buffer.
interface conv3_writeback_if #(parameter int AW = 12);
  logic          in_valid;
  logic [24:0]   in_acc;
  logic [24:0]   in_bias;
  logic          in_ready;
  logic          acc_clr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport master (output in_valid, in_acc, in_bias,
                  input  in_ready, acc_clr, mem_we, mem_addr, mem_wdata);
  modport slave  (input  in_valid, in_acc, in_bias,
                  output in_ready, acc_clr, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/conv3_writeback.sv
// conv3 output stage: bias add, round/shift, optional ReLU, int8 saturation,
// 4-byte packing and sequential writes to the output buffer.
module conv3_writeback #(parameter int AW = 12) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   count,
  input  logic [4:0]    shift,
  input  logic          relu_en,
  conv3_writeback_if.slave bus,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]        count_r, accepted;
  logic [4:0]         shift_r;
  logic               relu_r;
  logic [AW-1:0]      addr;
  logic [1:0]         lane;
  logic [23:0]        pack;
  logic signed [25:0] s1;
  logic               s1_vld;
  logic               ready, accept, last_accept;
  logic signed [26:0] s1x, rnd, r;
  logic [7:0]         b;
  logic               acc_clr_r, mem_we_r;
  logic [AW-1:0]      mem_addr_r;
  logic [31:0]        mem_wdata_r;

  assign ready       = (state == RUN) && (accepted < count_r);
  assign accept      = bus.in_valid && ready;
  assign last_accept = accept && (({1'b0, accepted} + 17'd1) == {1'b0, count_r});

  assign bus.in_ready  = ready;
  assign bus.acc_clr   = acc_clr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  always_ff @(posedge CLK) begin
    if (CLR) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = (count == 16'd0) ? DONE : RUN;
      RUN:     if (last_accept) state_nxt = DRAIN;
      // a partial word is flushed while lane != 0; DONE follows once it is gone
      DRAIN:   if (!s1_vld && lane == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // round-half-up shift in 27 bits so the rounding offset cannot overflow
  always_comb begin
    s1x = {s1[25], s1};
    rnd = s1x;
    if (shift_r != 5'd0) rnd = s1x + (27'sd1 <<< (shift_r - 5'd1));
    r = rnd >>> shift_r;
    if (relu_r && r < 27'sd0) r = 27'sd0;
    if (r > 27'sd127)        b = 8'h7F;
    else if (r < -27'sd128)  b = 8'h80;
    else                     b = r[7:0];
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      count_r     <= '0;
      accepted    <= '0;
      shift_r     <= '0;
      relu_r      <= 1'b0;
      addr        <= '0;
      lane        <= '0;
      pack        <= '0;
      s1          <= '0;
      s1_vld      <= 1'b0;
      acc_clr_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      acc_clr_r <= accept;
      mem_we_r  <= 1'b0;
      s1_vld    <= accept;
      if (state == IDLE && start) begin
        count_r  <= count;
        shift_r  <= shift;
        relu_r   <= relu_en;
        addr     <= base_addr;
        accepted <= '0;
        lane     <= '0;
        pack     <= '0;
      end
      if (accept) begin
        s1       <= $signed({bus.in_acc[24], bus.in_acc}) + $signed({bus.in_bias[24], bus.in_bias});
        accepted <= accepted + 16'd1;
      end
      if (s1_vld) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0: pack[7:0]   <= b;
          2'd1: pack[15:8]  <= b;
          2'd2: pack[23:16] <= b;
          default: begin
            mem_we_r    <= 1'b1;
            mem_wdata_r <= {b, pack};
            mem_addr_r  <= addr;
            addr        <= addr + 1'b1;
            pack        <= '0;
          end
        endcase
      end else if (state == DRAIN && lane != 2'd0) begin
        mem_we_r    <= 1'b1;
        mem_wdata_r <= {8'h00, pack};
        mem_addr_r  <= addr;
        addr        <= addr + 1'b1;
        pack        <= '0;
        lane        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv3_writeback.sv
// Randomized scoreboard bench for conv3_writeback: expected words come from an
// arithmetic reference model; a monitor checks every write and acc_clr pulse.
module tb_conv3_writeback;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [15:0] count = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic        busy, done;

  conv3_writeback_if #(.AW(12)) bus();

  conv3_writeback #(.AW(12)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .base_addr(base_addr), .count(count),
    .shift(shift), .relu_en(relu_en), .bus(bus), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct { int addr; longint data; } wr_t;

  int     checks = 0, failures = 0;
  int     cyc = 0;
  bit     mon_en = 0;
  wr_t    exp_wr_q[$];
  int     exp_clr_q[$];
  int     acc_a[$], bias_a[$];
  int     wr_cnt = 0, done_cnt = 0;
  int     last_we_cyc = 0, prev_we_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic longint ref_byte(input int acc, input int bias, input int sh, input bit relu);
    longint s, r;
    s = longint'(acc) + longint'(bias);
    r = s;
    if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r & 255;
  endfunction

  function automatic int rand25();
    int v;
    v = $urandom;
    return v >>> 7;
  endfunction

  // monitor: samples one step after the active edge
  always @(posedge CLK) begin
    #1;
    if (mon_en) begin
      if (bus.mem_we === 1'b1) begin
        if (exp_wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("wr_addr", longint'(bus.mem_addr), longint'(e.addr));
          chk("wr_data", longint'(bus.mem_wdata), e.data);
        end
        prev_we_cyc = last_we_cyc;
        last_we_cyc = cyc;
        wr_cnt++;
      end
      if (bus.acc_clr === 1'b1) begin
        if (exp_clr_q.size() == 0) chk("unexpected_acc_clr", 1, 0);
        else chk("acc_clr_cycle", cyc, exp_clr_q.pop_front());
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic push_expected(input int base, input int cnt, input int sh, input bit relu);
    int     addr;
    longint word;
    addr = base;
    word = 0;
    for (int k = 0; k < cnt; k++) begin
      word |= ref_byte(acc_a[k], bias_a[k], sh, relu) << (8 * (k % 4));
      if (k % 4 == 3 || k == cnt - 1) begin
        exp_wr_q.push_back('{addr, word});
        addr = (addr + 1) % 4096;
        word = 0;
      end
    end
  endtask

  // drives n results starting at index from; returns how many were accepted
  task automatic drive(input int from, input int n, input int gap, output int got);
    int  t;
    bit  v;
    int  a, bb;
    got = 0;
    t = 0;
    while (got < n && t < 2000) begin
      v  = (gap == 0) || ($urandom_range(99) >= gap);
      a  = acc_a[from + got];
      bb = bias_a[from + got];
      bus.in_valid = v;
      bus.in_acc   = a[24:0];
      bus.in_bias  = bb[24:0];
      if (gap == 0) chk("in_ready_run", bus.in_ready, 1);
      if (v && bus.in_ready) begin
        exp_clr_q.push_back(cyc + 1);
        got++;
      end
      @(negedge CLK);
      t++;
    end
    bus.in_valid = 1'b0;
    if (got < n) chk("accept_timeout", got, n);
  endtask

  task automatic run_job(input int base, input int cnt, input int sh, input bit relu,
                         input int gap, input bit poke_done);
    int t, got, start_cyc, wr0;
    wr0 = wr_cnt;
    push_expected(base, cnt, sh, relu);
    start = 1'b1; base_addr = 12'(base); count = 16'(cnt); shift = 5'(sh); relu_en = relu;
    start_cyc = cyc;
    @(negedge CLK);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    drive(0, cnt, gap, got);
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("done_seen", done, 1);
    if (cnt == 0) chk("done_latency_zero", cyc, start_cyc + 1);
    else          chk("done_after_last_we", cyc, last_we_cyc + 1);
    if (poke_done) begin
      start = 1'b1; count = 16'd5;
    end
    @(negedge CLK);
    start = 1'b0;
    chk("busy_cleared", busy, 0);
    chk("done_one_cycle", done, 0);
    if (poke_done) begin
      repeat (3) @(negedge CLK);
      chk("start_in_done_ignored", busy, 0);
    end
    chk("writes_issued", wr_cnt - wr0, (cnt + 3) / 4);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("clr_queue_drained", exp_clr_q.size(), 0);
  endtask

  task automatic set_stim(input int a[$], input int bs[$]);
    acc_a  = a;
    bias_a = bs;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_we"},    bus.mem_we, 0);
    chk({tag, "_acc_clr"},   bus.acc_clr, 0);
    chk({tag, "_in_ready"},  bus.in_ready, 0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
  endtask

  task automatic abort_job();
    int got, d0;
    acc_a.delete(); bias_a.delete();
    for (int k = 0; k < 12; k++) begin
      acc_a.push_back($urandom_range(255) - 128);
      bias_a.push_back(0);
    end
    push_expected(12'h100, 12, 0, 1'b0);
    start = 1'b1; base_addr = 12'h100; count = 16'd12; shift = 5'd0; relu_en = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    drive(0, 6, 0, got);
    chk("abort_first_word_written", exp_wr_q.size(), 2);
    exp_wr_q.delete();
    exp_clr_q.delete();
    d0 = done_cnt;
    CLR = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    start = 1'b0;
    check_idle_outputs("abort");
    repeat (6) @(negedge CLK);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_start_with_clr_ignored", busy, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_acc   = '0;
    bus.in_bias  = '0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    CLR = 1'b0;
    mon_en = 1;
    @(negedge CLK);

    set_stim('{1, -1, 127, -128}, '{0, 0, 0, 0});
    run_job(12'h010, 4, 0, 1'b0, 0, 1'b1);

    set_stim('{24, -24, 5000, -5000}, '{0, 0, 0, 0});
    run_job(12'h020, 4, 4, 1'b0, 0, 1'b0);

    set_stim('{-10, 10}, '{30, -30});
    run_job(12'h030, 2, 0, 1'b1, 0, 1'b0);

    set_stim('{3, -7, 100, -100, 55, -2}, '{1, 1, 1, 1, 1, 1});
    run_job(12'h040, 6, 0, 1'b0, 25, 1'b0);

    acc_a.delete(); bias_a.delete();
    run_job(12'h050, 0, 0, 1'b0, 0, 1'b0);

    set_stim('{1, 2, 3, 4, 5, 6, 7, 8}, '{0, 0, 0, 0, 0, 0, 0, 0});
    run_job(12'hFFF, 8, 0, 1'b0, 0, 1'b0);
    chk("wrap_spacing", last_we_cyc - prev_we_cyc, 4);

    abort_job();
    set_stim('{-50, 60, 70, -80, 9}, '{10, -10, 20, 0, 0});
    run_job(12'h200, 5, 1, 1'b1, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      int cnt;
      cnt = $urandom_range(20, 1);
      acc_a.delete(); bias_a.delete();
      for (int k = 0; k < cnt; k++) begin
        acc_a.push_back(rand25());
        bias_a.push_back(rand25());
      end
      run_job($urandom_range(4095), cnt, $urandom_range(24), 1'($urandom_range(1)),
              (j % 2 == 0) ? 0 : 30, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3_writeback.md
# conv3_writeback

Output stage of the conv3 accelerator path, sitting after the conv3 accumulating filter. It accepts finished 25-bit signed accumulator results and adds a per-result bias. It then rounds, shifts, optionally applies ReLU and saturates each result to int8. Four results are packed into a 32-bit word and written sequentially to the output buffer. It also pulses the filter's clear once each result has been captured, so the next accumulation starts from zero.

## Interface
- AW, 12, output-buffer word-address width
- CLK  in  1  clock; all state changes on posedge
- CLR  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; loads base_addr, count, shift, relu_en; ignored while busy
- base_addr  in  AW  first output word address
- count  in  16  number of results in this job
- shift  in  5  arithmetic right-shift amount, 0..24
- relu_en  in  1  clamp negative results to 0 before saturation
- in_valid  in  1  in_acc/in_bias valid
- in_acc  in  25  signed accumulator result (filter `out`)
- in_bias  in  25  signed bias for this result
- in_ready  out  1  high in RUN while accepted < count
- acc_clr  out  1  one-cycle pulse on each accepted result; drives filter CLR
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  AW  word address, valid with mem_we
- mem_wdata  out  32  packed bytes; lane 0 = bits 7:0
- busy  out  1  high from cycle after start until done inclusive
- done  out  1  one-cycle pulse at job end
- Reset values: every output is 0, state is IDLE, and all counters and pack registers are 0.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE to RUN: on start, latch the config and set addr=base_addr, accepted=0, lane=0. If count=0, go IDLE to DONE instead.
- Accept: in_valid & in_ready at an edge. On accept, increment accepted and assert acc_clr for the following cycle.
- Stage 1, registered at the accept edge: s1 = in_acc + in_bias, 26-bit signed, no overflow.
- Stage 2, computed combinationally from s1:
  - If shift > 0: r = (s1 + (1 << (shift-1))) >>> shift. Otherwise r = s1.
  - If relu_en and r < 0: r = 0.
  - Saturate r to [-128, 127], giving byte b.
- Pack: at the edge after stage 1, write b into lane `lane` of the pack register, then lane = lane + 1 mod 4.
  - If lane was 3, register mem_we=1, mem_wdata={b, pack[23:0]}, mem_addr=addr, then addr = addr + 1 mod 2^AW and clear the pack register.
- RUN to DRAIN: at the edge where accepted reaches count.
- DRAIN: wait for the stage-1 and pack pipeline to empty. If lane != 0, issue one final write with the unfilled upper lanes as 0. Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. busy is 0 from the next cycle.
- CLR in any state aborts the job immediately: the pending write is lost and no done pulse is issued.

## Timing
- Result accepted at edge E0 → byte packed at E1. If it fills lane 3, mem_we is high during the cycle after E1, i.e. 2 cycles after acceptance.
- acc_clr is high in the cycle after E0, so the filter clears at E1. The filter may assert its WE for the next result starting at E1.
- Throughput is one result per cycle with no bubbles, and in_ready stays high through RUN.
- A full-word tail's done pulse is 1 cycle after its last mem_we; a partial tail writes in DRAIN, with done 1 cycle later.
- Address wrap: base_addr = 2^AW-1 writes there, and the next write goes to 0.
- A start pulse coincident with CLR is ignored.
- A start pulse in the DONE cycle is ignored.

## Test plan
- Basic pack: shift=0, relu off, bias=0, count=4, acc={1,-1,127,-128} → one write at base, wdata=0x807FFF01, done 1 cycle later; acc_clr pulses exactly 4 times.
- Round/shift/saturate: shift=4, acc=24 with bias=0 → 2 (24+8=32, >>4); acc=-24 → -1 (-24+8=-16, >>4); acc=5000 → 127; acc=-5000 → -128.
- ReLU and bias: relu_en=1, acc=-10, bias=30 → 20; acc=10, bias=-30 → 0.
- Partial tail and zero count:
  - count=6 → two writes, the second with wdata upper 16 bits = 0.
  - count=0 → done 1 cycle after start, no mem_we.
- Back-to-back stream plus wrap: AW=12, base_addr=0xFFF, count=8, in_valid held high → writes at 0xFFF then 0x000, on consecutive-4-cycle spacing.
- Abort: CLR asserted mid-RUN → all outputs 0 next cycle, no done; a fresh start then runs correctly.
